// File: rtl/bit_error_injector_pkg.sv
// ============================================================================
// Module      : bit_error_injector_pkg
// Description : Shared mode encoding for the bit error injector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bit_error_injector_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_PASS     = 2'd0;
    localparam mode_t MODE_FIXED    = 2'd1;
    localparam mode_t MODE_PERIODIC = 2'd2;
    localparam mode_t MODE_SWEEP    = 2'd3;

endpackage

`default_nettype wire

// File: rtl/bit_error_injector_idx_to_mask.sv
// ============================================================================
// Module      : idx_to_mask
// Description : 1-based bit index to one-hot mask; 0 or out-of-range -> 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module idx_to_mask #(
    parameter int WORD_W = 7,
    parameter int IDX_W  = 3
) (
    input  logic [IDX_W-1:0]  idx,
    output logic [WORD_W-1:0] mask
);

    generate
        for (genvar g = 0; g < WORD_W; g++) begin : g_bit
            assign mask[g] = (idx == IDX_W'(g + 1));
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/bit_error_injector.sv
// ============================================================================
// Module      : bit_error_injector
// Description : Streaming 0/1/2-bit fault injector with a one-deep
//               valid/ready output register and saturating injection count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_error_injector
    import bit_error_injector_pkg::*;
#(
    parameter int WORD_W   = 7,
    parameter int IDX_W    = 3,
    parameter int PERIOD_W = 8,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_load,
    input  logic [1:0]          cfg_mode,
    input  logic [IDX_W-1:0]    cfg_idx_a,
    input  logic [IDX_W-1:0]    cfg_idx_b,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WORD_W-1:0]   in_word,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_W-1:0]   out_word,
    output logic [WORD_W-1:0]   out_err_mask,
    output logic [CNT_W-1:0]    inj_count
);

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(WORD_W);

    mode_t               r_mode;
    mode_t               w_mode_next;
    logic [IDX_W-1:0]    r_idx_a;
    logic [IDX_W-1:0]    r_idx_b;
    logic [PERIOD_W-1:0] r_period;
    logic [PERIOD_W-1:0] r_period_cnt;
    logic [IDX_W-1:0]    r_sweep_idx;
    logic                r_out_valid;
    logic [WORD_W-1:0]   r_out_word;
    logic [WORD_W-1:0]   r_out_mask;
    logic [CNT_W-1:0]    r_inj_count;

    logic [WORD_W-1:0]   w_mask_a;
    logic [WORD_W-1:0]   w_mask_b;
    logic [WORD_W-1:0]   w_mask_sweep;
    logic [WORD_W-1:0]   w_mask;
    logic                w_period_hit;
    logic                w_accept;

    idx_to_mask #(.WORD_W(WORD_W), .IDX_W(IDX_W)) u_mask_a (
        .idx  (r_idx_a),
        .mask (w_mask_a)
    );

    idx_to_mask #(.WORD_W(WORD_W), .IDX_W(IDX_W)) u_mask_b (
        .idx  (r_idx_b),
        .mask (w_mask_b)
    );

    idx_to_mask #(.WORD_W(WORD_W), .IDX_W(IDX_W)) u_mask_sweep (
        .idx  (r_sweep_idx),
        .mask (w_mask_sweep)
    );

    assign in_ready = ~r_out_valid | out_ready;
    assign w_accept = in_valid & in_ready;

    // Mode register doubles as the FSM state; config fields load alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode   <= MODE_PASS;
            r_idx_a  <= '0;
            r_idx_b  <= '0;
            r_period <= '0;
        end else begin
            r_mode <= w_mode_next;
            if (cfg_load) begin
                r_idx_a  <= cfg_idx_a;
                r_idx_b  <= cfg_idx_b;
                r_period <= cfg_period;
            end
        end
    end

    always_comb begin
        w_mode_next = r_mode;
        if (cfg_load) begin
            w_mode_next = cfg_mode;
        end
    end

    always_comb begin
        w_mask       = '0;
        w_period_hit = (r_period != '0) && (r_period_cnt == r_period - PERIOD_W'(1));
        case (r_mode)
            MODE_FIXED:    w_mask = w_mask_a ^ w_mask_b;
            MODE_PERIODIC: w_mask = w_period_hit ? (w_mask_a ^ w_mask_b) : '0;
            MODE_SWEEP:    w_mask = w_mask_sweep;
            default:       w_mask = '0;
        endcase
    end

    // A load in the same cycle as an accept wins: the word used the old
    // config and the counters restart rather than advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period_cnt <= '0;
            r_sweep_idx  <= IDX_W'(1);
        end else if (cfg_load) begin
            r_period_cnt <= '0;
            r_sweep_idx  <= IDX_W'(1);
        end else if (w_accept) begin
            if (r_mode == MODE_PERIODIC) begin
                if (r_period == '0 || w_period_hit) begin
                    r_period_cnt <= '0;
                end else begin
                    r_period_cnt <= r_period_cnt + PERIOD_W'(1);
                end
            end
            if (r_mode == MODE_SWEEP) begin
                if (r_sweep_idx >= c_last_idx) begin
                    r_sweep_idx <= '0;
                end else begin
                    r_sweep_idx <= r_sweep_idx + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_word  <= '0;
            r_out_mask  <= '0;
            r_inj_count <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_word  <= in_word ^ w_mask;
                r_out_mask  <= w_mask;
                if ((w_mask != '0) && !(&r_inj_count)) begin
                    r_inj_count <= r_inj_count + CNT_W'(1);
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_word     = r_out_word;
    assign out_err_mask = r_out_mask;
    assign inj_count    = r_inj_count;

endmodule

`default_nettype wire

// File: tb/tb_bit_error_injector.sv
// ============================================================================
// Module      : tb_bit_error_injector
// Description : Directed and randomized self-checking bench for bit_error_injector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_error_injector;
    import bit_error_injector_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_load;
    logic [1:0]  cfg_mode;
    logic [2:0]  cfg_idx_a;
    logic [2:0]  cfg_idx_b;
    logic [7:0]  cfg_period;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_word;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_word;
    logic [6:0]  out_err_mask;
    logic [15:0] inj_count;

    int n_checks = 0;
    int n_fail   = 0;

    bit_error_injector dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_load     (cfg_load),
        .cfg_mode     (cfg_mode),
        .cfg_idx_a    (cfg_idx_a),
        .cfg_idx_b    (cfg_idx_b),
        .cfg_period   (cfg_period),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_word      (in_word),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_word     (out_word),
        .out_err_mask (out_err_mask),
        .inj_count    (inj_count)
    );

    always #5 clk = ~clk;

    // Reference model: word-count based, computed from the injection rules.
    function automatic logic [6:0] oh(input int i);
        logic [6:0] r;
        r = '0;
        if (i >= 1 && i <= 7) r[i-1] = 1'b1;
        return r;
    endfunction

    int         m_mode, m_a, m_b, m_period, m_nper, m_nsw, m_cnt;
    logic       m_ov;
    logic [6:0] m_word, m_mask, m_mk;
    logic       m_acc;

    always_comb begin
        m_acc = in_valid && (!m_ov || out_ready);
        m_mk  = '0;
        case (m_mode)
            1: m_mk = oh(m_a) ^ oh(m_b);
            2: if (m_period != 0 && ((m_nper + 1) % m_period) == 0) m_mk = oh(m_a) ^ oh(m_b);
            3: m_mk = oh((m_nsw % 8) + 1);
            default: m_mk = '0;
        endcase
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode <= 0; m_a <= 0; m_b <= 0; m_period <= 0;
            m_nper <= 0; m_nsw <= 0; m_cnt <= 0;
            m_ov <= 1'b0; m_word <= '0; m_mask <= '0;
        end else begin
            if (m_acc) begin
                m_ov   <= 1'b1;
                m_word <= in_word ^ m_mk;
                m_mask <= m_mk;
                if (m_mk != 0 && m_cnt != 65535) m_cnt <= m_cnt + 1;
                if (!cfg_load && m_mode == 2) m_nper <= m_nper + 1;
                if (!cfg_load && m_mode == 3) m_nsw <= m_nsw + 1;
            end else if (out_ready) begin
                m_ov <= 1'b0;
            end
            if (cfg_load) begin
                m_mode <= int'(cfg_mode); m_a <= int'(cfg_idx_a); m_b <= int'(cfg_idx_b);
                m_period <= int'(cfg_period); m_nper <= 0; m_nsw <= 0;
            end
        end
    end

    task automatic do_load(input logic [1:0] mode, input int a, input int b, input int p);
        @(negedge clk);
        cfg_mode = mode; cfg_idx_a = 3'(a); cfg_idx_b = 3'(b); cfg_period = 8'(p);
        cfg_load = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    task automatic send_word(input logic [6:0] w);
        @(negedge clk);
        in_valid = 1'b1; in_word = w; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cfg_load = 1'b0; cfg_mode = '0; cfg_idx_a = '0; cfg_idx_b = '0;
        cfg_period = '0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (out_word !== 7'h00) begin n_fail++; $display("FAIL reset_out_word got %h want 00", out_word); end
        n_checks++; if (out_err_mask !== 7'h00) begin n_fail++; $display("FAIL reset_mask got %h want 00", out_err_mask); end
        n_checks++; if (inj_count !== 16'h0) begin n_fail++; $display("FAIL reset_inj_count got %h want 0", inj_count); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_pass();
        do_load(MODE_PASS, 0, 0, 0);
        for (int i = 0; i <= 128; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_word !== 7'(i - 1) || out_err_mask !== 7'h00) begin
                    n_fail++;
                    $display("FAIL pass_stream[%0d] got v=%b w=%h m=%h want v=1 w=%h m=00", i - 1, out_valid, out_word, out_err_mask, 7'(i - 1));
                end
            end
            in_valid = (i < 128); in_word = 7'(i); out_ready = 1'b1;
        end
        in_valid = 1'b0;
        n_checks++; if (inj_count !== 16'h0) begin n_fail++; $display("FAIL pass_inj_count got %h want 0", inj_count); end
    endtask

    task automatic test_fixed();
        int base;
        base = m_cnt;
        do_load(MODE_FIXED, 3, 0, 0);
        send_word(7'h55);
        n_checks++; if (out_word !== 7'h51 || out_err_mask !== 7'h04) begin n_fail++; $display("FAIL fixed_a3 got w=%h m=%h want w=51 m=04", out_word, out_err_mask); end
        n_checks++; if (inj_count !== 16'(base + 1)) begin n_fail++; $display("FAIL fixed_a3_count got %0d want %0d", inj_count, base + 1); end
        do_load(MODE_FIXED, 3, 3, 0);
        send_word(7'h55);
        n_checks++; if (out_word !== 7'h55 || out_err_mask !== 7'h00) begin n_fail++; $display("FAIL fixed_same got w=%h m=%h want w=55 m=00", out_word, out_err_mask); end
        n_checks++; if (inj_count !== 16'(base + 1)) begin n_fail++; $display("FAIL fixed_same_count got %0d want %0d", inj_count, base + 1); end
        do_load(MODE_FIXED, 0, 7, 0);
        send_word(7'h00);
        n_checks++; if (out_word !== 7'h40 || out_err_mask !== 7'h40) begin n_fail++; $display("FAIL fixed_b7 got w=%h m=%h want w=40 m=40", out_word, out_err_mask); end
        n_checks++; if (inj_count !== 16'(base + 2)) begin n_fail++; $display("FAIL fixed_b7_count got %0d want %0d", inj_count, base + 2); end
    endtask

    task automatic test_periodic();
        logic [6:0] exp_m [7];
        int base;
        exp_m = '{7'h00, 7'h00, 7'h01, 7'h00, 7'h00, 7'h01, 7'h00};
        base = m_cnt;
        do_load(MODE_PERIODIC, 1, 0, 3);
        for (int i = 0; i <= 7; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_checks++;
                if (out_err_mask !== exp_m[i-1] || out_word !== exp_m[i-1]) begin
                    n_fail++;
                    $display("FAIL periodic3[%0d] got w=%h m=%h want %h", i - 1, out_word, out_err_mask, exp_m[i-1]);
                end
            end
            in_valid = (i < 7); in_word = 7'h00;
        end
        n_checks++; if (inj_count !== 16'(base + 2)) begin n_fail++; $display("FAIL periodic3_count got %0d want %0d", inj_count, base + 2); end
        do_load(MODE_PERIODIC, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            send_word(7'h00);
            n_checks++; if (out_err_mask !== 7'h00) begin n_fail++; $display("FAIL periodic0[%0d] got m=%h want 00", i, out_err_mask); end
        end
        do_load(MODE_PERIODIC, 2, 5, 1);
        for (int i = 0; i < 3; i++) begin
            send_word(7'h7F);
            n_checks++; if (out_err_mask !== 7'h12 || out_word !== 7'h6D) begin n_fail++; $display("FAIL periodic1[%0d] got w=%h m=%h want w=6d m=12", i, out_word, out_err_mask); end
        end
    endtask

    task automatic test_sweep();
        logic [6:0] exp;
        do_load(MODE_SWEEP, 0, 0, 0);
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp = ((i - 1) % 8 < 7) ? 7'(1 << ((i - 1) % 8)) : 7'h00;
                n_checks++;
                if (out_err_mask !== exp || out_word !== exp) begin
                    n_fail++;
                    $display("FAIL sweep[%0d] got w=%h m=%h want %h", i - 1, out_word, out_err_mask, exp);
                end
            end
            in_valid = (i < 16); in_word = 7'h00;
        end
        for (int i = 0; i < 3; i++) send_word(7'h00);
        do_load(MODE_SWEEP, 0, 0, 0);
        send_word(7'h00);
        n_checks++; if (out_err_mask !== 7'h01) begin n_fail++; $display("FAIL sweep_restart got m=%h want 01", out_err_mask); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] q_word[$];
        logic [6:0] q_mask[$];
        logic [6:0] held, v, mk;
        int k;
        do_load(MODE_SWEEP, 0, 0, 0);
        k = 0; v = 7'h20; held = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (cyc == 4) held = out_word;
            if (cyc >= 5 && cyc <= 9) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_word !== held) begin
                    n_fail++;
                    $display("FAIL bp_hold[%0d] got v=%b w=%h want v=1 w=%h", cyc, out_valid, out_word, held);
                end
            end
            in_valid = (cyc < 13); in_word = v; out_ready = !(cyc >= 4 && cyc <= 8);
            #1;
            if (cyc >= 4 && cyc <= 8) begin
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want 0", cyc, in_ready); end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (q_word.size() == 0) begin
                    n_fail++; $display("FAIL bp_dup got w=%h with nothing outstanding", out_word);
                end else if (out_word !== q_word[0] || out_err_mask !== q_mask[0]) begin
                    n_fail++; $display("FAIL bp_order got w=%h m=%h want w=%h m=%h", out_word, out_err_mask, q_word[0], q_mask[0]);
                end
                if (q_word.size() != 0) begin void'(q_word.pop_front()); void'(q_mask.pop_front()); end
            end
            if (in_valid && in_ready) begin
                mk = (k % 8 < 7) ? 7'(1 << (k % 8)) : 7'h00;
                q_word.push_back(v ^ mk); q_mask.push_back(mk);
                k++; v = v + 7'h1;
            end
        end
        in_valid = 1'b0;
        n_checks++; if (q_word.size() != 0) begin n_fail++; $display("FAIL bp_lost got %0d outstanding want 0", q_word.size()); end
        n_checks++; if (k != 8) begin n_fail++; $display("FAIL bp_accepted got %0d want 8", k); end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== m_ov || inj_count !== 16'(m_cnt) ||
                (m_ov && (out_word !== m_word || out_err_mask !== m_mask))) begin
                n_fail++;
                $display("FAIL rand[%0d] got v=%b w=%h m=%h c=%0d want v=%b w=%h m=%h c=%0d",
                         cyc, out_valid, out_word, out_err_mask, inj_count, m_ov, m_word, m_mask, m_cnt);
            end
            cfg_load   = ($urandom_range(0, 19) == 0);
            cfg_mode   = 2'($urandom_range(0, 3));
            cfg_idx_a  = 3'($urandom_range(0, 7));
            cfg_idx_b  = 3'($urandom_range(0, 7));
            cfg_period = 8'($urandom_range(0, 4));
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 2) != 0);
            in_word    = 7'($urandom);
            #1;
            n_checks++;
            if (in_ready !== (!m_ov || out_ready)) begin
                n_fail++; $display("FAIL rand_in_ready[%0d] got %b want %b", cyc, in_ready, (!m_ov || out_ready));
            end
        end
        cfg_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_async_reset();
        do_load(MODE_SWEEP, 0, 0, 0);
        @(negedge clk);
        in_valid = 1'b1; in_word = 7'h00; out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_out_valid got %b want 0", out_valid); end
        n_checks++; if (inj_count !== 16'h0) begin n_fail++; $display("FAIL arst_inj_count got %0d want 0", inj_count); end
        n_checks++; if (out_word !== 7'h00 || out_err_mask !== 7'h00) begin n_fail++; $display("FAIL arst_out got w=%h m=%h want 00 00", out_word, out_err_mask); end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        send_word(7'h2A);
        n_checks++; if (out_word !== 7'h2A || out_err_mask !== 7'h00) begin n_fail++; $display("FAIL arst_mode_pass got w=%h m=%h want w=2a m=00", out_word, out_err_mask); end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_pass();
        test_fixed();
        test_periodic();
        test_sweep();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
